// File: rtl/pc_seq_ctrl.sv
// PC sequencing and hazard controller for the fetch stage: next-PC select, load-use stall,
// branch hold/resolve, jump redirect and halt. Optional perf counters under PC_SEQ_PERF_EN.
module pc_seq_ctrl #(
    parameter int BR_LAT = 1,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_branch,
    input  logic       id_jump,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_zero,
    input  logic       halt_req,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic [1:0] state
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_BR_WAIT = 2'b01,
        ST_HALT    = 2'b10
    } state_e;

    localparam logic [1:0] SRC_PC1  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JMP  = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BR_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hz;
    logic             run_now;

    assign hz = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // A HALT cycle with halt_req already dropped is treated exactly like RUN.
    assign run_now = (state_q != ST_BR_WAIT) && !((state_q == ST_HALT) && halt_req);

    always_comb begin
        pc_we        = 1'b1;
        pc_src       = SRC_PC1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (!reset) begin
            pc_we        = 1'b0;
            pc_src       = SRC_HOLD;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_RUN;
            cnt_d        = '0;
        end else if (state_q == ST_BR_WAIT) begin
            if (cnt_q != '0) begin
                pc_we        = 1'b0;
                pc_src       = SRC_HOLD;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                cnt_d        = cnt_q - CNT_W'(1);
            end else begin
                if (ex_zero) begin
                    pc_src      = SRC_BR;
                    if_id_flush = 1'b1;
                end
                state_d = ST_RUN;
            end
        end else if (!run_now || halt_req) begin
            pc_we        = 1'b0;
            pc_src       = SRC_HOLD;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = ST_HALT;
        end else if (hz) begin
            pc_we        = 1'b0;
            pc_src       = SRC_HOLD;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = ST_RUN;
        end else if (id_jump) begin
            pc_src      = SRC_JMP;
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
        end else if (id_branch) begin
            // PC stays at branch+1 so the not-taken path can refetch it on resolution.
            pc_we       = 1'b0;
            pc_src      = SRC_HOLD;
            if_id_flush = 1'b1;
            cnt_d       = CNT_LOAD;
            state_d     = ST_BR_WAIT;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!pc_we)      perf_stall_q <= sat_inc(perf_stall_q);
            if (if_id_flush) perf_flush_q <= sat_inc(perf_flush_q);
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: BR_LAT=1 and BR_LAT=3 instances on shared inputs,
// compared each cycle against a cycle-age based reference model.
module tb_pc_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_branch = 1'b0, id_jump = 1'b0, ex_memread = 1'b0, ex_zero = 1'b0, halt_req = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;

    logic       pc_we1, if_id_we1, if_id_flush1, id_ex_bubble1;
    logic [1:0] pc_src1, state1;
    logic       pc_we3, if_id_we3, if_id_flush3, id_ex_bubble3;
    logic [1:0] pc_src3, state3;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_stall1, perf_flush1, perf_stall3, perf_flush3;
`endif

    int checks = 0;
    int errors = 0;

    int lat[2]     = '{1, 3};
    int m_age[2]   = '{0, 0};   // cycles since a branch left ID; 0 = none pending
    bit m_halt[2]  = '{0, 0};
    int m_stall[2] = '{0, 0};
    int m_flush[2] = '{0, 0};

    always #5 clk = ~clk;

    pc_seq_ctrl #(.BR_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .id_branch(id_branch), .id_jump(id_jump),
        .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_zero(ex_zero), .halt_req(halt_req), .pc_we(pc_we1), .pc_src(pc_src1),
        .if_id_we(if_id_we1), .if_id_flush(if_id_flush1), .id_ex_bubble(id_ex_bubble1),
        .state(state1)
`ifdef PC_SEQ_PERF_EN
        , .perf_stall(perf_stall1), .perf_flush(perf_flush1)
`endif
    );

    pc_seq_ctrl #(.BR_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .id_branch(id_branch), .id_jump(id_jump),
        .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_zero(ex_zero), .halt_req(halt_req), .pc_we(pc_we3), .pc_src(pc_src3),
        .if_id_we(if_id_we3), .if_id_flush(if_id_flush3), .id_ex_bubble(id_ex_bubble3),
        .state(state3)
`ifdef PC_SEQ_PERF_EN
        , .perf_stall(perf_stall3), .perf_flush(perf_flush3)
`endif
    );

    // Expected {pc_we, pc_src, if_id_we, if_id_flush, id_ex_bubble, state} for this cycle.
    task automatic model(input int i, output logic [7:0] e, output int na, output bit nh);
        bit         hzd;
        logic       we, ifwe, fl, bb;
        logic [1:0] src, st;
        hzd = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        we = 1'b1; src = 2'd0; ifwe = 1'b1; fl = 1'b0; bb = 1'b0; na = 0; nh = 1'b0;
        st = (m_age[i] > 0) ? 2'd1 : (m_halt[i] ? 2'd2 : 2'd0);
        if (!reset) begin
            we = 1'b0; ifwe = 1'b0; fl = 1'b1; bb = 1'b1; st = 2'd0;
        end else if (m_age[i] > 0) begin
            if (m_age[i] < lat[i]) begin
                we = 1'b0; fl = 1'b1; bb = 1'b1; na = m_age[i] + 1;
            end else if (ex_zero) begin
                src = 2'd1; fl = 1'b1;
            end
        end else if (halt_req) begin
            we = 1'b0; ifwe = 1'b0; bb = 1'b1; nh = 1'b1;
        end else if (hzd) begin
            we = 1'b0; ifwe = 1'b0; bb = 1'b1;
        end else if (id_jump) begin
            src = 2'd2; fl = 1'b1;
        end else if (id_branch) begin
            we = 1'b0; fl = 1'b1; na = 1;
        end
        if (!we) src = 2'd3;
        e = {we, src, ifwe, fl, bb, st};
    endtask

    task automatic cyc(input string tag);
        logic [7:0] e, o;
        int         nage[2];
        bit         nhalt[2];
        int         inc_s[2], inc_f[2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model(i, e, nage[i], nhalt[i]);
            o = (i == 0) ? {pc_we1, pc_src1, if_id_we1, if_id_flush1, id_ex_bubble1, state1}
                         : {pc_we3, pc_src3, if_id_we3, if_id_flush3, id_ex_bubble3, state3};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s lat=%0d observed=%b expected=%b", tag, lat[i], o, e);
            end
`ifdef PC_SEQ_PERF_EN
            checks++;
            assert (((i == 0) ? perf_stall1 : perf_stall3) === (reset ? 32'(m_stall[i]) : 32'd0)) else begin
                errors++;
                $error("FAIL %s_perf_stall lat=%0d observed=%0d expected=%0d", tag, lat[i],
                       (i == 0) ? perf_stall1 : perf_stall3, reset ? m_stall[i] : 0);
            end
            checks++;
            assert (((i == 0) ? perf_flush1 : perf_flush3) === (reset ? 32'(m_flush[i]) : 32'd0)) else begin
                errors++;
                $error("FAIL %s_perf_flush lat=%0d observed=%0d expected=%0d", tag, lat[i],
                       (i == 0) ? perf_flush1 : perf_flush3, reset ? m_flush[i] : 0);
            end
`endif
            inc_s[i] = (reset && !e[7]) ? 1 : 0;
            inc_f[i] = (reset && e[3]) ? 1 : 0;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_age[i] = 0; m_halt[i] = 1'b0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                m_age[i] = nage[i]; m_halt[i] = nhalt[i];
                m_stall[i] += inc_s[i]; m_flush[i] += inc_f[i];
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_branch = 1'b0; id_jump = 1'b0; ex_memread = 1'b0; ex_zero = 1'b0; halt_req = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    endtask

    initial begin
        #1;
        reset = 1'b0;
        repeat (3) cyc("reset");
        reset = 1'b1;
        repeat (2) cyc("idle");

        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cyc("hz_rs");
        ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        cyc("hz_rt");
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        cyc("hz_r0");
        idle_inputs();
        cyc("hz_clear");

        id_branch = 1'b1;
        cyc("br_t");
        id_branch = 1'b0; ex_zero = 1'b1;
        repeat (4) cyc("br_taken");
        ex_zero = 1'b0;
        id_branch = 1'b1;
        cyc("br_nt");
        id_branch = 1'b0;
        repeat (4) cyc("br_not_taken");

        id_branch = 1'b1;
        cyc("br_rst_t");
        id_branch = 1'b0; ex_zero = 1'b1;
        cyc("br_rst_t1");
        reset = 1'b0;
        cyc("br_rst_t2");
        reset = 1'b1;
        repeat (3) cyc("br_rst_after");
        ex_zero = 1'b0;

        id_jump = 1'b1; id_branch = 1'b1;
        cyc("jmp_br");
        idle_inputs();
        cyc("jmp_after");

        id_jump = 1'b1; ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
        cyc("hz_jmp");
        ex_memread = 1'b0;
        cyc("jmp_deferred");
        idle_inputs();
        cyc("jmp_done");

        reset = 1'b0;
        cyc("halt_rst");
        reset = 1'b1;
        halt_req = 1'b1;
        repeat (4) cyc("halt");
        halt_req = 1'b0;
        repeat (2) cyc("halt_release");

        halt_req = 1'b1;
        cyc("halt_br");
        halt_req = 1'b0; id_branch = 1'b1;
        cyc("halt_exit_br");
        id_branch = 1'b0;
        repeat (3) cyc("halt_exit_wait");

        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 59) != 0);
            halt_req   = ($urandom_range(0, 9) == 0);
            id_branch  = ($urandom_range(0, 3) == 0);
            id_jump    = ($urandom_range(0, 5) == 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_zero    = ($urandom_range(0, 1) == 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rt      = 5'($urandom_range(0, 3));
            cyc("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
